cpu_bus_master: RTL and testbench
=================================

Name: cpu_bus_master

Overview:
- Famicom CPU-side bus initiator: drives m2, romsel, cpu_rw, address and data toward a cartridge, as a 2A03 would.
- Used in the cartridge test harness and the flash-dumper/programmer board to exercise the multicart core from the console side.
- Converts a valid/ready request stream into cycle-exact CPU bus cycles. m2 free-runs continuously because cartridge logic clocks on m2.
- Captures read data and synchronizes the cartridge irq line.

Parameters:
M2_LOW_CYCLES, 3, clk periods per m2-low phase (legal range 2..15)
M2_HIGH_CYCLES, 3, clk periods per m2-high phase (legal range 1..15)
IDLE_ADDR, 16'h0000, address used for idle (dummy read) bus cycles

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted this clk when req_valid is also high
req_addr  input  16  CPU address
req_rw  input  1  1 = read, 0 = write
req_wdata  input  8  write data
rsp_valid  output  1  one-clk pulse: a request's bus cycle completed
rsp_rdata  output  8  data captured by the last read request
m2  output  1  CPU phi2
romsel  output  1  active-low: equals ~(m2 & addr[15])
cpu_rw  output  1  bus R/W
cpu_addr  output  15  bus A14..A0
cpu_data_out  output  8  write data toward cartridge
cpu_data_oe  output  1  drive enable for cpu_data_out
cpu_data_in  input  8  data from cartridge
irq_in  input  1  cartridge irq, active-low, asynchronous
irq_sync  output  1  irq_in after a 2-flop synchronizer, active-low

Behaviour:
- Reset values (applied asynchronously):
  - m2=0, romsel=1, cpu_rw=1, cpu_addr=IDLE_ADDR[14:0], cpu_data_oe=0, cpu_data_out=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, irq_sync=1.
  - FSM=LOW with phase counter cnt=0; no request pending.
- All outputs are registered.
- Bus cycle FSM, two states, cnt resets to 0 on every state change:
  - LOW: m2=0, romsel=1. Runs for M2_LOW_CYCLES clks, then goes to HIGH.
  - HIGH: m2=1. Runs for M2_HIGH_CYCLES clks, then goes to LOW.
- Bus cycle period = M2_LOW_CYCLES + M2_HIGH_CYCLES clks. m2 toggles regardless of request traffic.
- Hold rule:
  - cpu_addr, cpu_rw, cpu_data_out and cpu_data_oe stay unchanged during LOW cnt=0, the first clk after m2 falls.
  - The next cycle's values are applied in LOW cnt=1.
  - Purpose: mappers latching on the m2 falling edge see stable address and data.
- romsel is registered together with m2: it goes low on the same edge m2 rises if addr[15]=1, and high on the same edge m2 falls.
- Handshake:
  - req_ready=1 only during the last clk of HIGH (cnt=M2_HIGH_CYCLES-1).
  - A request is accepted on that clk edge if req_valid=1 and is latched into a pending register.
  - The pending request drives the next bus cycle. Back-to-back requests therefore use consecutive bus cycles, one per period.
  - If no request is accepted, the next cycle is an idle read: addr=IDLE_ADDR, rw=1.
- Write cycle: cpu_rw=0, cpu_data_out=wdata from LOW cnt=1. cpu_data_oe=1 from HIGH cnt=0 through LOW cnt=0 of the following cycle (hold).
- Read cycle:
  - cpu_rw=1, cpu_data_oe=0.
  - cpu_data_in is sampled on the last clk of HIGH.
  - rsp_rdata is updated to the sample and rsp_valid=1 on the next clk, LOW cnt=0.
- Write completion: rsp_valid pulses at the same position; rsp_rdata is unchanged.
- Idle cycles: rsp_valid never pulses; rsp_rdata is unchanged.
- Latency: request accepted at edge E → m2 falls at E → rsp_valid high in the clk after edge E + M2_LOW_CYCLES + M2_HIGH_CYCLES.
- cpu_addr carries addr[14:0]; addr[15] is visible only through romsel.
- irq_sync is a plain 2-flop synchronizer of irq_in with reset value 1.
- Reset mid-cycle: the pending request is discarded with no response, all outputs return to reset values, and the FSM restarts at LOW cnt=0.
- Requests presented while req_ready=0 are ignored. The requester must hold req_valid until accepted.

Test Plan:
1. Reset then no requests (defaults) → m2 period 6 clks, 3 low/3 high; cpu_addr=0, rw=1, romsel stays 1, rsp_valid never pulses.
2. Read $8000 with cpu_data_in=8'hA5 → romsel low exactly while m2=1 of that cycle; rsp_valid one pulse; rsp_rdata=8'hA5; next clk cpu_addr=0.
3. Write $6000←8'h3C → cpu_rw=0 and oe=1 over HIGH plus one LOW clk; romsel stays 1; cpu_addr=15'h6000 held through the clk after m2 falls; rsp_valid pulses; rsp_rdata unchanged.
4. Reads $8000, $8001, $C000 with req_valid held continuously → three consecutive bus cycles, no idle gap; three rsp_valid pulses 6 clks apart with matching data.
5. Assert reset during HIGH of a write → m2=0, oe=0, rw=1 immediately; no rsp_valid; after release, first req_ready appears 6 clks later.
6. irq_in falls → irq_sync falls exactly 2 clks later; M2_LOW_CYCLES=2, M2_HIGH_CYCLES=1 → 3-clk period and hold rule still met.

Source files
------------

// File: rtl/cpu_bus_master_if.sv
// cpu_bus_master_if: request stream plus Famicom CPU-side bus signals around cpu_bus_master.
interface cpu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_rw;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;
    logic        irq_in;
    logic        irq_sync;
    modport master (
        input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_in,
        output req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
               cpu_data_out, cpu_data_oe, irq_sync
    );
    modport slave (
        output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_in,
        input  req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
               cpu_data_out, cpu_data_oe, irq_sync
    );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: 2A03-style bus initiator turning a valid/ready request stream into free-running m2 bus cycles.
module cpu_bus_master #(
    parameter int unsigned M2_LOW_CYCLES  = 3,
    parameter int unsigned M2_HIGH_CYCLES = 3,
    parameter logic [15:0] IDLE_ADDR      = 16'h0000
) (
    input logic              clk,
    input logic              reset,
    cpu_bus_master_if.master bus
);
    typedef enum logic {LOW, HIGH} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        m2_q, m2_d, romsel_q, romsel_d, rw_q, rw_d, oe_q, oe_d, a15_q, a15_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d, rdata_q, rdata_d, p_wdata_q, p_wdata_d;
    logic        ready_q, ready_d, rsp_q, rsp_d, cyc_req_q, cyc_req_d;
    logic        p_valid_q, p_valid_d, p_rw_q, p_rw_d;
    logic [15:0] p_addr_q, p_addr_d;
    logic [1:0]  irq_q, irq_d;
    logic        last_low, last_high, load, accept, pend_wr;

    always_comb begin
        last_low  = state_q == LOW && cnt_q == 4'(M2_LOW_CYCLES - 1);
        last_high = state_q == HIGH && cnt_q == 4'(M2_HIGH_CYCLES - 1);
        state_d   = last_low ? HIGH : last_high ? LOW : state_q;
        cnt_d     = (last_low || last_high) ? 4'd0 : cnt_q + 4'd1;
        m2_d      = state_d == HIGH;
        ready_d   = state_d == HIGH && cnt_d == 4'(M2_HIGH_CYCLES - 1);
        // the pending slot is refreshed at every ready edge; nothing offered means an idle cycle
        accept    = ready_q && bus.req_valid;
        p_valid_d = ready_q ? bus.req_valid : p_valid_q;
        p_addr_d  = accept ? bus.req_addr : p_addr_q;
        p_rw_d    = accept ? bus.req_rw : p_rw_q;
        p_wdata_d = accept ? bus.req_wdata : p_wdata_q;
        // bus values move one clk after m2 falls so falling-edge latches see them stable
        load      = state_q == LOW && cnt_q == 4'd0;
        pend_wr   = p_valid_q && !p_rw_q;
        addr_d    = load ? (p_valid_q ? p_addr_q[14:0] : IDLE_ADDR[14:0]) : addr_q;
        a15_d     = load ? (p_valid_q ? p_addr_q[15] : IDLE_ADDR[15]) : a15_q;
        rw_d      = load ? !pend_wr : rw_q;
        dout_d    = (load && pend_wr) ? p_wdata_q : dout_q;
        cyc_req_d = load ? p_valid_q : cyc_req_q;
        oe_d      = last_low ? !rw_q : load ? 1'b0 : oe_q;
        romsel_d  = !(m2_d && a15_q);
        rsp_d     = last_high && cyc_req_q;
        rdata_d   = (rsp_d && rw_q) ? bus.cpu_data_in : rdata_q;
        irq_d     = {irq_q[0], bus.irq_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            m2_q      <= 1'b0;
            romsel_q  <= 1'b1;
            rw_q      <= 1'b1;
            oe_q      <= 1'b0;
            a15_q     <= IDLE_ADDR[15];
            addr_q    <= IDLE_ADDR[14:0];
            dout_q    <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            rsp_q     <= 1'b0;
            cyc_req_q <= 1'b0;
            p_valid_q <= 1'b0;
            p_rw_q    <= 1'b1;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            irq_q     <= 2'b11;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m2_q      <= m2_d;
            romsel_q  <= romsel_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            a15_q     <= a15_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            rsp_q     <= rsp_d;
            cyc_req_q <= cyc_req_d;
            p_valid_q <= p_valid_d;
            p_rw_q    <= p_rw_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = rsp_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.m2           = m2_q;
    assign bus.romsel       = romsel_q;
    assign bus.cpu_rw       = rw_q;
    assign bus.cpu_addr     = addr_q;
    assign bus.cpu_data_out = dout_q;
    assign bus.cpu_data_oe  = oe_q;
    assign bus.irq_sync     = irq_q[1];
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: two cpu_bus_master configurations checked every clk against a bus-cycle-level model.
module tb_cpu_bus_master;
    localparam int NI = 2;
    typedef struct packed {logic req; logic rw; logic [15:0] addr; logic [7:0] wd;} cyc_t;

    function automatic int lc(int i); return i == 0 ? 3 : 2; endfunction
    function automatic int hc(int i); return i == 0 ? 3 : 1; endfunction
    function automatic cyc_t idle(int i);
        return '{req: 1'b0, rw: 1'b1, addr: (i == 0 ? 16'h0000 : 16'h8123), wd: 8'h00};
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rv[NI], rrw[NI], irq[NI], rdy[NI], rsp[NI], m2[NI], rs[NI], crw[NI], oe[NI], irqs[NI];
    logic [15:0] raddr[NI];
    logic [7:0]  rwd[NI], din[NI], rdata[NI], dout[NI];
    logic [14:0] caddr[NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cpu_bus_master_if bus();
        cpu_bus_master #(
            .M2_LOW_CYCLES(g == 0 ? 3 : 2),
            .M2_HIGH_CYCLES(g == 0 ? 3 : 1),
            .IDLE_ADDR(g == 0 ? 16'h0000 : 16'h8123)
        ) dut (.clk(clk), .reset(reset), .bus(bus.master));
        assign bus.req_valid   = rv[g];
        assign bus.req_addr    = raddr[g];
        assign bus.req_rw      = rrw[g];
        assign bus.req_wdata   = rwd[g];
        assign bus.cpu_data_in = din[g];
        assign bus.irq_in      = irq[g];
        assign rdy[g]   = bus.req_ready;
        assign rsp[g]   = bus.rsp_valid;
        assign rdata[g] = bus.rsp_rdata;
        assign m2[g]    = bus.m2;
        assign rs[g]    = bus.romsel;
        assign crw[g]   = bus.cpu_rw;
        assign caddr[g] = bus.cpu_addr;
        assign dout[g]  = bus.cpu_data_out;
        assign oe[g]    = bus.cpu_data_oe;
        assign irqs[g]  = bus.irq_sync;
    end

    // model: t clks since reset; cycle k = t/period; cur is cycle k's request, prv is cycle k-1's
    int         t[NI];
    cyc_t       cur[NI], prv[NI];
    logic [7:0] mrd[NI];
    logic [1:0] irqh[NI];

    always @(posedge clk or posedge reset)
        for (int i = 0; i < NI; i++)
            if (reset) begin
                t[i]    <= 0;
                cur[i]  <= idle(i);
                prv[i]  <= idle(i);
                mrd[i]  <= 8'h00;
                irqh[i] <= 2'b11;
            end else begin
                t[i]    <= t[i] + 1;
                irqh[i] <= {irqh[i][0], irq[i]};
                if (t[i] % (lc(i) + hc(i)) == lc(i) + hc(i) - 1) begin
                    prv[i] <= cur[i];
                    cur[i] <= rv[i] ? '{req: 1'b1, rw: rrw[i], addr: raddr[i], wd: rwd[i]} : idle(i);
                    if (cur[i].req && cur[i].rw) mrd[i] <= din[i];
                end
            end

    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   rs_low0, oe_hi0, m2_hi0, m2_hi1;
    int   rsp_at[$];
    logic [7:0] rsp_dat[$];
    logic rdy_prev[NI], acc[NI];
    bit   auto_req[NI], rnd_irq;
    int   dmode[NI];

    function automatic void chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at clk %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            int   p, pos;
            logic hi, e_oe;
            cyc_t c;
            p    = lc(i) + hc(i);
            pos  = t[i] % p;
            hi   = pos >= lc(i);
            c    = pos == 0 ? prv[i] : cur[i];
            e_oe = c.req && !c.rw && (pos == 0 || hi);
            chk("m2", i, 16'(m2[i]), 16'(hi));
            chk("romsel", i, 16'(rs[i]), 16'(!(hi && cur[i].addr[15])));
            chk("cpu_rw", i, 16'(crw[i]), 16'(c.rw));
            chk("cpu_addr", i, 16'(caddr[i]), 16'(c.addr[14:0]));
            chk("cpu_data_oe", i, 16'(oe[i]), 16'(e_oe));
            if (e_oe || t[i] == 0) chk("cpu_data_out", i, 16'(dout[i]), 16'(c.wd));
            chk("req_ready", i, 16'(rdy[i]), 16'(pos == p - 1));
            chk("rsp_valid", i, 16'(rsp[i]), 16'(pos == 0 && prv[i].req));
            chk("rsp_rdata", i, 16'(rdata[i]), 16'(mrd[i]));
            chk("irq_sync", i, 16'(irqs[i]), 16'(irqh[i][1]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) acc[i] = rdy_prev[i] && rv[i] && !reset;
        compare_all();
        if (rsp[0]) begin
            rsp_at.push_back(cyc);
            rsp_dat.push_back(rdata[0]);
        end
        if (!rs[0]) rs_low0++;
        if (oe[0]) oe_hi0++;
        if (m2[0]) m2_hi0++;
        if (m2[1]) m2_hi1++;
        for (int i = 0; i < NI; i++) begin
            rdy_prev[i] = rdy[i];
            if (auto_req[i] && (acc[i] || !rv[i])) begin
                rv[i]    = $urandom_range(0, 2) != 0;
                raddr[i] = 16'($urandom);
                rrw[i]   = 1'($urandom);
                rwd[i]   = 8'($urandom);
            end
            if (dmode[i] == 1) din[i] = caddr[i][7:0] ^ 8'h5A;
            if (dmode[i] == 2) din[i] = 8'($urandom);
            if (rnd_irq && $urandom_range(0, 7) == 0) irq[i] = !irq[i];
        end
    endtask

    task automatic send(int i, logic [15:0] a, logic r, logic [7:0] w, bit keep);
        rv[i] = 1'b1; raddr[i] = a; rrw[i] = r; rwd[i] = w;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (acc[i]) break;
        end
        chk("accepted", i, 16'(acc[i]), 16'd1);
        if (!keep) rv[i] = 1'b0;
    endtask

    task automatic wait_rsps(int n, int budget);
        for (int k = 0; k < budget && rsp_at.size() < n; k++) tick();
        chk("rsp_count", 0, 16'(rsp_at.size()), 16'(n));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rv[i] = 0; rrw[i] = 1; raddr[i] = 0; rwd[i] = 0; din[i] = 0; irq[i] = 1;
            rdy_prev[i] = 0; acc[i] = 0; auto_req[i] = 0; dmode[i] = 0;
        end
        rnd_irq = 0;
        reset = 0;
        #1 reset = 1;
        tick(); tick();
        reset = 0;
        chk("rst_m2", 0, 16'(m2[0]), 16'd0);
        chk("rst_romsel", 0, 16'(rs[0]), 16'd1);
        chk("rst_rw", 0, 16'(crw[0]), 16'd1);
        chk("rst_addr", 1, 16'(caddr[1]), 16'h0123);
        chk("rst_oe", 0, 16'(oe[0]), 16'd0);
        chk("rst_ready", 0, 16'(rdy[0]), 16'd0);
        chk("rst_rdata", 0, 16'(rdata[0]), 16'd0);
        chk("rst_irq", 0, 16'(irqs[0]), 16'd1);

        rs_low0 = 0; m2_hi0 = 0; rsp_at.delete();
        repeat (18) tick();
        chk("idle_m2_high", 0, 16'(m2_hi0), 16'd9);
        chk("idle_romsel_low", 0, 16'(rs_low0), 16'd0);
        chk("idle_rsp", 0, 16'(rsp_at.size()), 16'd0);

        din[0] = 8'hA5; rs_low0 = 0; rsp_at.delete(); rsp_dat.delete();
        send(0, 16'h8000, 1'b1, 8'h00, 0);
        wait_rsps(1, 30);
        chk("rd_romsel_low", 0, 16'(rs_low0), 16'd3);
        chk("rd_data", 0, 16'(rsp_dat[0]), 16'h00A5);
        tick();
        chk("rd_addr_after", 0, 16'(caddr[0]), 16'd0);
        chk("rd_single_pulse", 0, 16'(rsp[0]), 16'd0);

        rs_low0 = 0; oe_hi0 = 0; rsp_at.delete();
        send(0, 16'h6000, 1'b0, 8'h3C, 0);
        wait_rsps(1, 30);
        chk("wr_addr_hold", 0, 16'(caddr[0]), 16'h6000);
        chk("wr_rw_hold", 0, 16'(crw[0]), 16'd0);
        chk("wr_dout", 0, 16'(dout[0]), 16'h003C);
        chk("wr_rdata_kept", 0, 16'(rdata[0]), 16'h00A5);
        chk("wr_oe_clks", 0, 16'(oe_hi0), 16'd4);
        chk("wr_romsel_low", 0, 16'(rs_low0), 16'd0);
        tick();
        chk("wr_oe_off", 0, 16'(oe[0]), 16'd0);
        chk("wr_rw_back", 0, 16'(crw[0]), 16'd1);

        dmode[0] = 1; rsp_at.delete(); rsp_dat.delete();
        send(0, 16'h8000, 1'b1, 8'h00, 1);
        send(0, 16'h8001, 1'b1, 8'h00, 1);
        send(0, 16'hC000, 1'b1, 8'h00, 0);
        wait_rsps(3, 40);
        chk("b2b_d0", 0, 16'(rsp_dat[0]), 16'h005A);
        chk("b2b_d1", 0, 16'(rsp_dat[1]), 16'h005B);
        chk("b2b_d2", 0, 16'(rsp_dat[2]), 16'h005A);
        chk("b2b_gap01", 0, 16'(rsp_at[1] - rsp_at[0]), 16'd6);
        chk("b2b_gap12", 0, 16'(rsp_at[2] - rsp_at[1]), 16'd6);

        send(0, 16'h8000, 1'b0, 8'h77, 0);
        for (int k = 0; k < 20 && !(m2[0] && !crw[0]); k++) tick();
        chk("wr_high_reached", 0, 16'(oe[0]), 16'd1);
        reset = 1;
        #1;
        chk("rst_mid_m2", 0, 16'(m2[0]), 16'd0);
        chk("rst_mid_oe", 0, 16'(oe[0]), 16'd0);
        chk("rst_mid_rw", 0, 16'(crw[0]), 16'd1);
        rsp_at.delete();
        tick(); tick();
        reset = 0;
        begin
            int k;
            for (k = 1; k <= 20; k++) begin
                tick();
                if (rdy[0]) break;
            end
            chk("rst_first_ready", 0, 16'(k), 16'd5);
        end
        repeat (12) tick();
        chk("rst_no_rsp", 0, 16'(rsp_at.size()), 16'd0);

        irq[0] = 1'b0;
        tick();
        chk("irq_1clk", 0, 16'(irqs[0]), 16'd1);
        tick();
        chk("irq_2clk", 0, 16'(irqs[0]), 16'd0);
        irq[0] = 1'b1;

        m2_hi1 = 0;
        repeat (12) tick();
        chk("fast_m2_high", 1, 16'(m2_hi1), 16'd4);
        send(1, 16'h1234, 1'b0, 8'h99, 0);
        for (int k = 0; k < 20 && !(oe[1] && !m2[1]); k++) tick();
        chk("fast_hold_addr", 1, 16'(caddr[1]), 16'h1234);
        chk("fast_hold_rw", 1, 16'(crw[1]), 16'd0);
        tick();
        chk("fast_idle_addr", 1, 16'(caddr[1]), 16'h0123);
        chk("fast_oe_off", 1, 16'(oe[1]), 16'd0);

        for (int i = 0; i < NI; i++) begin auto_req[i] = 1; dmode[i] = 2; end
        rnd_irq = 1;
        repeat (3000) tick();
        for (int i = 0; i < NI; i++) begin auto_req[i] = 0; rv[i] = 0; end
        rnd_irq = 0;
        repeat (12) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
